playback_controller: RTL
========================

# playback_controller

Sequencing controller for the auto-play note engine. It debounces the play, stop and song-select buttons and runs a play/pause/stop state machine. From that it drives the engine's `play_state` enable and its active-low `reset`, so every start or song change begins at note 0 and speed changes are only possible while paused. It sits between the board buttons and the auto-play engine, and is gated by the top-level mode selector.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: cycles an input must be stable before it is accepted (20 ms at 100 MHz).
- `RESTART_CYCLES`, default 4: cycles the engine reset is held low on restart or stop.
- `clk` in 1: system clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `auto_en` in 1: auto mode selected; synchronous level.
- `btn_play` in 1: raw play/pause button, active-high.
- `btn_stop` in 1: raw stop button, active-high.
- `btn_song` in 2: raw song next [0] / previous [1] buttons.
- `play_state` out 1: engine run enable.
- `player_rst_n` out 1: engine reset, active-low.
- `song_select` out 2: debounced one-cycle song pulses to the engine.
- `status` out 2: current FSM state encoding.

## Operation
- **Debounce.** Each of the 4 raw inputs passes through a 2-flop synchronizer and then a stability counter.
  - The counter resets on any change of the synchronized value.
  - Once the counter reaches `DEBOUNCE_CYCLES-1`, the value is accepted.
  - An accepted 0→1 transition produces a single-cycle pulse: `play_p`, `stop_p`, `song_p[1:0]`.
- **`song_select`** equals `song_p`, registered. Both bits are never high together; if they coincide, bit 0 wins.
- **FSM states** (`status` encoding): IDLE=0, PLAYING=1, PAUSED=2, RESTART=3.
  - A separate `go_idle` flag records whether RESTART exits to IDLE (stop) or to PLAYING (start or song change).
- **IDLE:** `play_state`=0, `player_rst_n`=1.
  - `play_p` → RESTART, with `go_idle`=0.
  - `song_p` passes through only; the state does not change.
- **RESTART:** `play_state`=0, `player_rst_n`=0.
  - The counter counts 0..`RESTART_CYCLES-1`.
  - On terminal count → IDLE if `go_idle`, else PLAYING.
  - Inputs are ignored, except `stop_p`, which sets `go_idle`=1.
- **PLAYING:** `play_state`=1, `player_rst_n`=1. Priority order:
  1. `stop_p` → RESTART with `go_idle`=1.
  2. Any `song_p` bit → RESTART with `go_idle`=0, so the new song auto-starts.
  3. `play_p` → PAUSED.
- **PAUSED:** `play_state`=0, `player_rst_n`=1. The engine position is held, and the engine accepts speed changes in this state.
  1. `stop_p` → RESTART with `go_idle`=1.
  2. `song_p` → RESTART with `go_idle`=1, so the song changes and the controller waits in IDLE.
  3. `play_p` → PLAYING.
- **`auto_en`=0:**
  - In PLAYING or PAUSED → RESTART with `go_idle`=1.
  - In IDLE, RESTART → IDLE is enforced on the next exit.
  - `play_p` is ignored while `auto_en`=0.
- **Counter widths.** Debounce counter: $clog2(DEBOUNCE_CYCLES). Restart counter: $clog2(RESTART_CYCLES)+1. Neither wraps: each saturates or clears on state exit.

## Timing
- **Reset values:** FSM=IDLE, `go_idle`=1, counters=0, synchronizers=0, accepted levels=0, `play_state`=0, `player_rst_n`=1, `song_select`=0, `status`=0.
- **Press-to-pulse latency:** 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles from a stable raw edge to the pulse.
- **Pulse to outputs:** all outputs are registered and change 1 cycle after the pulse.
- **Bounce:** a glitch shorter than `DEBOUNCE_CYCLES` produces no pulse. Release must also be stable before the next press is accepted.
- **Start sequence:** `play_p` in IDLE gives `player_rst_n` low for exactly `RESTART_CYCLES` cycles, then `play_state`=1 in the following cycle.
- **Simultaneous events** are resolved by the priority order above. At most one state transition happens per cycle.
- **Reset assertion mid-operation:** all outputs go to their reset values immediately (asynchronous). Deassertion is released synchronously through the flops.

## Structure
- **Shared package:** state encodings `ST_IDLE`, `ST_PLAYING`, `ST_PAUSED`, `ST_RESTART`, and the default debounce and restart constants. These sit alongside the existing song and speed constants.
- **Sub-module:** `btn_debounce`, parameterized by `DEBOUNCE_CYCLES`, with ports clk, reset, raw in, pulse out. It is instantiated 4 times.
- **This module:** the FSM, the restart counter and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `RESTART_CYCLES`=4.
- **Reset:** pulse `reset` low → `status`=0, `play_state`=0, `player_rst_n`=1, `song_select`=0.
- **Start:** `auto_en`=1, hold `btn_play` for 10 cycles → pulse 7 cycles after the rise; `player_rst_n`=0 for 4 cycles; then `play_state`=1, `status`=1.
- **Bounce rejection:** toggle `btn_play` 1,0,1,0 on consecutive cycles → no pulse, `status` stays 0.
- **Pause/resume:** PLAYING, press play → `status`=2, `play_state`=0. Press again → `status`=1, with no `player_rst_n` low.
- **Song change:**
  - PLAYING, press `btn_song[0]` → `song_select`=01 for 1 cycle, restart of 4 cycles, `status`=1.
  - Same from PAUSED → ends with `status`=0.
- **Stop priority and mode exit:**
  - Play and stop pulses in the same cycle while PLAYING → RESTART, then `status`=0.
  - `auto_en` dropped while PLAYING → `player_rst_n` low for 4 cycles, then `status`=0.

Source files
------------

// File: rtl/playback_controller_pkg.sv
// Shared encodings and defaults for the auto-play note engine sequencing blocks.
package playback_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PLAYING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_RESTART = 2'd3
   } state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 2_000_000;
   localparam int unsigned DEF_RESTART_CYCLES  = 4;
   localparam int unsigned SONG_W              = 2;

endpackage

// File: rtl/btn_debounce.sv
// Raw button to single-cycle press pulse: 2-flop sync, stability counter,
// accepted level, rising-edge pulse on the accepted level.
module btn_debounce
   import playback_controller_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse
);

   localparam int unsigned      CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1, sync_2, sync_q;
   logic             level;
   logic [CNT_W-1:0] cnt;
   logic             stable, accept;

   // sync_q only detects a change of the synchronized value; it is not a third sync stage
   assign stable = (sync_2 == sync_q);
   assign accept = stable && (cnt == CNT_TC) && (level != sync_2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_q <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         sync_q <= sync_2;
         if (!stable)
            cnt <= '0;
         else if (cnt != CNT_TC)
            cnt <= cnt + CNT_W'(1);
         if (accept)
            level <= sync_2;
         pulse <= accept && sync_2;
      end
   end

endmodule

// File: rtl/playback_controller.sv
// Play/pause/stop sequencer driving the auto-play engine's run enable and reset.
//   state      | meaning
//   ST_IDLE    | stopped, engine out of reset, not running
//   ST_PLAYING | engine running
//   ST_PAUSED  | engine held at its position, speed may change
//   ST_RESTART | engine reset held low; exits to IDLE when go_idle, else PLAYING
module playback_controller
   import playback_controller_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned RESTART_CYCLES  = DEF_RESTART_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              auto_en,
   input  logic              btn_play,
   input  logic              btn_stop,
   input  logic [SONG_W-1:0] btn_song,
   output logic              play_state,
   output logic              player_rst_n,
   output logic [SONG_W-1:0] song_select,
   output logic [1:0]        status
);

   localparam int unsigned      RST_W  = $clog2(RESTART_CYCLES) + 1;
   localparam logic [RST_W-1:0] RST_TC = RST_W'(RESTART_CYCLES - 1);

   state_t            state, state_next;
   logic              go_idle, go_idle_next;
   logic [RST_W-1:0]  rst_cnt;
   logic              play_p, stop_p;
   logic [SONG_W-1:0] song_p;
   logic              quit, song_any;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play
      (.clk(clk), .reset(reset), .raw(btn_play), .pulse(play_p));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop
      (.clk(clk), .reset(reset), .raw(btn_stop), .pulse(stop_p));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_song0
      (.clk(clk), .reset(reset), .raw(btn_song[0]), .pulse(song_p[0]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_song1
      (.clk(clk), .reset(reset), .raw(btn_song[1]), .pulse(song_p[1]));

   // leaving auto mode behaves exactly like a stop press
   assign quit     = stop_p | ~auto_en;
   assign song_any = |song_p;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         go_idle     <= 1'b1;
         rst_cnt     <= '0;
         song_select <= '0;
      end else begin
         state       <= state_next;
         go_idle     <= go_idle_next;
         rst_cnt     <= (state == ST_RESTART && state_next == ST_RESTART) ? rst_cnt + RST_W'(1) : '0;
         song_select <= {song_p[1] & ~song_p[0], song_p[0]};
      end
   end

   always_comb begin
      state_next   = state;
      go_idle_next = go_idle;
      case (state)
         ST_IDLE: begin
            if (!auto_en) begin
               go_idle_next = 1'b1;
            end else if (play_p) begin
               state_next   = ST_RESTART;
               go_idle_next = 1'b0;
            end
         end
         ST_RESTART: begin
            if (quit)
               go_idle_next = 1'b1;
            if (rst_cnt == RST_TC)
               state_next = go_idle_next ? ST_IDLE : ST_PLAYING;
         end
         ST_PLAYING: begin
            if (quit) begin
               state_next   = ST_RESTART;
               go_idle_next = 1'b1;
            end else if (song_any) begin
               state_next   = ST_RESTART;
               go_idle_next = 1'b0;
            end else if (play_p) begin
               state_next   = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (quit || song_any) begin
               state_next   = ST_RESTART;
               go_idle_next = 1'b1;
            end else if (play_p) begin
               state_next   = ST_PLAYING;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      play_state   = 1'b0;
      player_rst_n = 1'b1;
      case (state)
         ST_PLAYING: play_state   = 1'b1;
         ST_RESTART: player_rst_n = 1'b0;
         default: ;
      endcase
   end

   assign status = state;

endmodule
